// File: rtl/cfa_window_gen.sv
// Streaming WIN x WIN Bayer window generator: WIN-1 line buffers feed a column shift register; one window per interior pixel.
// Optional centre colour phase output is built only when CFA_PHASE_OUT_EN is defined.
module cfa_window_gen #(
  parameter int DATA_W   = 12,
  parameter int MAX_COLS = 2048,
  parameter int WIN      = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [10:0]                rowMax,
  input  logic [10:0]                colMax,
  input  logic [1:0]                 patternSelect,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [DATA_W-1:0]          pix_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [WIN*WIN*DATA_W-1:0]  win_data,
  output logic [10:0]                win_row,
  output logic [10:0]                win_col,
  output logic [1:0]                 win_phase,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int H  = (WIN - 1) / 2;
  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int WW = WIN * WIN * DATA_W;
  localparam logic [10:0] WIN_L  = 11'(WIN);
  localparam logic [10:0] WM1_L  = 11'(WIN - 1);
  localparam logic [10:0] H_L    = 11'(H);
  localparam logic [11:0] MAXC_L = 12'(MAX_COLS);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q;
  logic [10:0]       row_max_q, col_max_q, row_q, col_q;
  logic [WW-1:0]     shift_q, shift_d, out_dat_q;
  logic              out_vld_q, done_q, err_q;
  logic [10:0]       out_row_q, out_col_q;
  logic [10:0]       crow_c, ccol_c;
  logic [DATA_W-1:0] lbuf [WIN-1][MAX_COLS];
  logic [DATA_W-1:0] rd   [WIN-1];
  logic [AW-1:0]     col_idx;
  logic              acc, last_col, last_row, win_hit, cfg_ok;

  assign col_idx   = col_q[AW-1:0];
  assign pix_ready = (state_q == RUN) && (!out_vld_q || win_ready);
  assign acc       = pix_valid && pix_ready;
  assign last_col  = (col_q == col_max_q - 11'd1);
  assign last_row  = (row_q == row_max_q - 11'd1);
  assign win_hit   = (row_q >= WM1_L) && (col_q >= WM1_L);
  assign cfg_ok    = (WIN_L <= rowMax) && (WIN_L <= colMax) && ({1'b0, colMax} <= MAXC_L);
  assign crow_c    = row_q - H_L;
  assign ccol_c    = col_q - H_L;

  always_comb begin
    for (int k = 0; k < WIN - 1; k++) begin
      rd[k] = lbuf[k][col_idx];
    end
  end

  // Shift left one column; new right column is oldest line on top, live pixel at the bottom.
  always_comb begin
    shift_d = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        shift_d[(r*WIN+c)*DATA_W +: DATA_W] = shift_q[(r*WIN+c+1)*DATA_W +: DATA_W];
      end
      if (r == WIN - 1) begin
        shift_d[(r*WIN+WIN-1)*DATA_W +: DATA_W] = pix_data;
      end else begin
        shift_d[(r*WIN+WIN-1)*DATA_W +: DATA_W] = rd[WIN-2-r];
      end
    end
  end

  // Line buffers are plain storage; every frame rewrites them before use, so no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      lbuf[0][col_idx] <= pix_data;
      for (int k = 0; k < WIN - 2; k++) begin
        lbuf[k+1][col_idx] <= lbuf[k][col_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_max_q <= '0;
      col_max_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      shift_q   <= '0;
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (acc) begin
        shift_q <= shift_d;
      end
      if (acc && win_hit) begin
        out_vld_q <= 1'b1;
        out_dat_q <= shift_d;
        out_row_q <= crow_c;
        out_col_q <= ccol_c;
      end else if (win_ready) begin
        out_vld_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              row_max_q <= rowMax;
              col_max_q <= colMax;
              row_q     <= '0;
              col_q     <= '0;
              state_q   <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (acc) begin
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + 11'd1;
              if (last_row) begin
                state_q <= FLUSH;
              end
            end else begin
              col_q <= col_q + 11'd1;
            end
          end
        end
        FLUSH: begin
          if (!out_vld_q || win_ready) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CFA_PHASE_OUT_EN
  logic [1:0] pat_q, out_phase_q;

  // Pattern tables reduce to XOR of the centre parity index with the pattern code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q       <= 2'b00;
      out_phase_q <= 2'b00;
    end else begin
      if ((state_q == IDLE) && start && cfg_ok) begin
        pat_q <= patternSelect;
      end
      if (acc && win_hit) begin
        out_phase_q <= {crow_c[0], ccol_c[0]} ^ pat_q;
      end
    end
  end

  assign win_phase = out_phase_q;
`else
  logic unused_pattern;
  assign unused_pattern = ^patternSelect;
  assign win_phase      = 2'b00;
`endif

  assign win_valid = out_vld_q;
  assign win_data  = out_dat_q;
  assign win_row   = out_row_q;
  assign win_col   = out_col_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule
